// File: rtl/jk_bank_driver.sv
// Drives J/K of an external JK flip-flop bank toward a target word, verifies by readback, retries.
// Optional per-bit drive mask enabled with `define JK_DRIVE_MASK_EN.
module jk_bank_driver #(
   parameter int WIDTH     = 4,
   parameter int DC_MODE   = 0,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
`ifdef JK_DRIVE_MASK_EN
   input  logic [WIDTH-1:0] drv_mask,
`endif
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       retries
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] mask_q, mask_d, mask_in;
   logic [3:0]       cnt, cnt_d;
   logic [3:0]       ret_d;
   logic [WIDTH-1:0] j_d, k_d;
   logic             done_d, err_d, ready_d, busy_d;
   logic             match;

`ifdef JK_DRIVE_MASK_EN
   assign mask_in = drv_mask;
`else
   assign mask_in = '1;
`endif

   // Returns {J, K}; masked-out bits are left untouched.
   function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] m);
      logic [WIDTH-1:0] diff;
      diff = (q ^ t) & m;
      if (DC_MODE == 1)
         excite = {diff, diff};
      else
         excite = {diff & t, diff & q};
   endfunction

   assign match = (((q_in ^ tgt_q) & mask_q) == '0);

   always_comb begin
      state_d = state;
      tgt_d   = tgt_q;
      mask_d  = mask_q;
      cnt_d   = cnt;
      ret_d   = retries;
      j_d     = '0;
      k_d     = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: begin
            if (tgt_valid && tgt_ready) begin
               tgt_d        = tgt_data;
               mask_d       = mask_in;
               cnt_d        = '0;
               {j_d, k_d}   = excite(q_in, tgt_data, mask_in);
               state_d      = DRIVE;
            end
         end
         DRIVE: state_d = CHECK;
         CHECK: begin
            if (match) begin
               done_d  = 1'b1;
               ret_d   = cnt;
               state_d = IDLE;
            end else if (cnt < 4'(MAX_RETRY)) begin
               cnt_d      = cnt + 4'd1;
               {j_d, k_d} = excite(q_in, tgt_q, mask_q);
               state_d    = DRIVE;
            end else begin
               err_d   = 1'b1;
               ret_d   = cnt;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = !ready_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tgt_q     <= '0;
         mask_q    <= '0;
         cnt       <= '0;
         retries   <= '0;
         j_out     <= '0;
         k_out     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         tgt_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         tgt_q     <= tgt_d;
         mask_q    <= mask_d;
         cnt       <= cnt_d;
         retries   <= ret_d;
         j_out     <= j_d;
         k_out     <= k_d;
         done      <= done_d;
         err       <= err_d;
         tgt_ready <= ready_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle encodings) each on its own JK bank model.
module tb_jk_bank_driver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       tgt_valid = 1'b0;
   logic [3:0] tgt_data = '0;
   logic [3:0] drv_mask = 4'b1111;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] stuck0 = '0;
   logic [3:0] bank0 = '0, bank1 = '0;
   logic [3:0] q0, q1;
   logic [3:0] j0, k0, j1, k1, ret0, ret1;
   logic       rdy0, busy0, done0, err0, rdy1, busy1, done1, err1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   assign q0 = bank0 & ~stuck0;
   assign q1 = bank1 & ~stuck0;

   function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                          input logic [3:0] k);
      for (int unsigned i = 0; i < 4; i++)
         jk_next[i] = (j[i] & k[i]) ? ~q[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : q[i];
   endfunction

   always @(posedge clk) begin
      if (load) begin
         bank0 <= load_val;
         bank1 <= load_val;
      end else begin
         bank0 <= jk_next(q0, j0, k0);
         bank1 <= jk_next(q1, j1, k1);
      end
   end

   jk_bank_driver #(.WIDTH(4), .DC_MODE(0), .MAX_RETRY(2)) dut0 (
      .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
`ifdef JK_DRIVE_MASK_EN
      .drv_mask(drv_mask),
`endif
      .tgt_ready(rdy0), .q_in(q0), .j_out(j0), .k_out(k0), .busy(busy0),
      .done(done0), .err(err0), .retries(ret0));

   jk_bank_driver #(.WIDTH(4), .DC_MODE(1), .MAX_RETRY(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
`ifdef JK_DRIVE_MASK_EN
      .drv_mask(drv_mask),
`endif
      .tgt_ready(rdy1), .q_in(q1), .j_out(j1), .k_out(k1), .busy(busy1),
      .done(done1), .err(err1), .retries(ret1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] v);
      load = 1'b1;
      load_val = v;
      tick();
      load = 1'b0;
   endtask

   task automatic request(input logic [3:0] t);
      tgt_valid = 1'b1;
      tgt_data = t;
      tick();
      tgt_valid = 1'b0;
   endtask

   initial begin
      // reset
      #2 reset_n = 1'b0;
      #1;
      check("rst_outs0", {j0, k0, rdy0, busy0, done0, err0, ret0}, '0);
      check("rst_outs1", {j1, k1, rdy1, busy1, done1, err1, ret1}, '0);
      tick();
      check("rst_held_rdy", rdy0, 1'b0);
      reset_n = 1'b1;
      check("rel_rdy_pre", rdy0, 1'b0);
      tick();
      check("rel_rdy_post", {rdy0, rdy1, busy0}, 3'b110);

      // set/reset encoding, 0000 -> 1010
      preload(4'b0000);
      request(4'b1010);
      check("t1_drive_jk0", {j0, k0}, {4'b1010, 4'b0000});
      check("t1_drive_st", {rdy0, busy0}, 2'b01);
      check("t1_drive_jk1", {j1, k1}, {4'b1010, 4'b1010});
      tick();
      check("t1_check_jk", {j0, k0, done0, busy0}, {8'h00, 1'b0, 1'b1});
      check("t1_bank", q0, 4'b1010);
      tick();
      check("t1_done", {done0, err0, rdy0, busy0, ret0}, {4'b1010, 4'd0});
      check("t1_done1", {done1, err1, ret1}, {2'b10, 4'd0});
      tick();
      check("t1_done_pulse", done0, 1'b0);

      // toggle encoding, 1100 -> 0110
      preload(4'b1100);
      request(4'b0110);
      check("t2_drive_jk1", {j1, k1}, {4'b1010, 4'b1010});
      check("t2_drive_jk0", {j0, k0}, {4'b0010, 4'b1000});
      tick();
      check("t2_bank1", q1, 4'b0110);
      tick();
      check("t2_done1", {done1, err1, ret1}, {2'b10, 4'd0});
      check("t2_done0", {done0, ret0}, {1'b1, 4'd0});
      tick();

      // bit0 stuck at 0 exhausts retries
      stuck0 = 4'b0001;
      preload(4'b0000);
      request(4'b0001);
      for (int unsigned a = 0; a < 3; a++) begin
         check($sformatf("t3_drive%0d", a), {j0, k0, j1, k1}, {4'b0001, 4'b0000, 4'b0001, 4'b0001});
         tick();
         check($sformatf("t3_check%0d", a), {j0, k0, done0, err0, busy0}, {8'h00, 3'b001});
         tick();
      end
      check("t3_err0", {done0, err0, rdy0, ret0}, {3'b011, 4'd2});
      check("t3_err1", {done1, err1, ret1}, {2'b01, 4'd2});
      tick();
      check("t3_err_pulse", {err0, err1}, 2'b00);
      stuck0 = 4'b0000;

      // target equals bank; back-to-back request in done cycle
      preload(4'b0101);
      request(4'b0101);
      check("t4_drive", {j0, k0, j1, k1, busy0}, {16'h0000, 1'b1});
      tick();
      tick();
      check("t4_done", {done0, rdy0, ret0}, {2'b11, 4'd0});
      request(4'b0000);
      check("t4_b2b_drive0", {j0, k0, busy0}, {4'b0000, 4'b0101, 1'b1});
      check("t4_b2b_drive1", {j1, k1}, {4'b0101, 4'b0101});
      tick();
      tick();
      check("t4_b2b_done", {done0, done1, q0}, {2'b11, 4'b0000});
      tick();

      // reset during DRIVE
      preload(4'b0000);
      request(4'b1111);
      check("t5_drive", {j0, busy0}, {4'b1111, 1'b1});
      #2 reset_n = 1'b0;
      #1;
      check("t5_async", {j0, k0, j1, k1, busy0, busy1, rdy0}, '0);
      tick();
      tick();
      #2 reset_n = 1'b1;
      tick();
      check("t5_rdy", {rdy0, rdy1, done0, err0, done1, err1}, 6'b110000);
      tick();
      check("t5_no_pulse", {done0, err0, done1, err1, busy0}, '0);

`ifdef JK_DRIVE_MASK_EN
      // masked drive, bit3 stuck
      stuck0 = 4'b1000;
      drv_mask = 4'b0011;
      preload(4'b0000);
      request(4'b1111);
      drv_mask = 4'b1111;
      check("t6_drive0", {j0, k0}, {4'b0011, 4'b0000});
      check("t6_drive1", {j1, k1}, {4'b0011, 4'b0011});
      tick();
      tick();
      check("t6_done", {done0, err0, ret0, done1, err1}, {2'b10, 4'd0, 2'b10});
      tick();
      stuck0 = 4'b0000;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
